quad_encoder_counter: RTL

Parametrised quadrature rotary-encoder decoder and position counter. It synchronises and debounces the raw A/B sensor lines and decodes them at x1, x2 or x4 resolution, selectable at run time. It maintains a wrapping or saturating position count and emits per-step direction pulses for downstream UI and control logic. It sits directly behind the encoder pins.

---
 rtl/enc_pkg.sv | 66 ++++++
 rtl/enc_input_filter.sv | 65 ++++++
 rtl/quad_encoder_counter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/enc_pkg.sv
// Shared definitions for the quadrature encoder decoder: resolution modes,
// Gray-code states and the transition classifier used by the counter.
package enc_pkg;

  typedef enum logic [1:0] {
    ENC_X1   = 2'd0,
    ENC_X2   = 2'd1,
    ENC_X4   = 2'd2,
    ENC_RSVD = 2'd3
  } enc_mode_e;

  // {A,B} Gray states in clockwise order
  localparam logic [1:0] GRAY_S0 = 2'b00;
  localparam logic [1:0] GRAY_S1 = 2'b10;
  localparam logic [1:0] GRAY_S2 = 2'b11;
  localparam logic [1:0] GRAY_S3 = 2'b01;

  typedef struct packed {
    logic cw;
    logic ccw;
    logic err;
  } enc_event_t;

  function automatic logic [1:0] cw_next(input logic [1:0] s);
    logic [1:0] n;
    case (s)
      GRAY_S0: n = GRAY_S1;
      GRAY_S1: n = GRAY_S2;
      GRAY_S2: n = GRAY_S3;
      default: n = GRAY_S0;
    endcase
    return n;
  endfunction

  // Classifies one filtered transition; reserved mode decodes as x1.
  function automatic enc_event_t decode_step(input logic [1:0] mode,
                                             input logic [1:0] prev_ab,
                                             input logic [1:0] cur_ab);
    enc_event_t ev;
    logic a_rise;
    logic a_fall;
    ev     = '0;
    a_rise = !prev_ab[1] && cur_ab[1];
    a_fall = prev_ab[1] && !cur_ab[1];
    if (cur_ab == ~prev_ab) begin
      ev.err = 1'b1;
    end else if (cur_ab != prev_ab) begin
      case (mode)
        ENC_X4: begin
          ev.cw  = (cur_ab == cw_next(prev_ab));
          ev.ccw = (prev_ab == cw_next(cur_ab));
        end
        ENC_X2: begin
          ev.cw  = (a_rise && !cur_ab[0]) || (a_fall && cur_ab[0]);
          ev.ccw = (a_rise && cur_ab[0]) || (a_fall && !cur_ab[0]);
        end
        default: begin
          ev.cw  = a_rise && !cur_ab[0];
          ev.ccw = a_rise && cur_ab[0];
        end
      endcase
    end
    return ev;
  endfunction

endpackage

// File: rtl/enc_input_filter.sv
// Two-flop synchroniser and run-length debounce for one encoder line.
// stable reports that the line has sat at its filtered level for DEBOUNCE_CYC cycles.
module enc_input_filter #(
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic filt,
  output logic stable
);

  localparam int RUN_W = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(DEBOUNCE_CYC - 1);
  localparam logic [RUN_W-1:0] STAB_MAX = RUN_W'(DEBOUNCE_CYC);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             filt_q, filt_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [RUN_W-1:0] stab_q, stab_d;

  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    filt_d  = filt_q;
    run_d   = '0;
    stab_d  = stab_q;
    if (sync2_q != filt_q) begin
      if (run_q == RUN_LAST) begin
        filt_d = sync2_q;
      end else begin
        run_d = run_q + 1'b1;
      end
    end
    // Stability also looks at the first flop so an edge still in flight blocks it
    if ((sync2_q == filt_q) && (sync1_q == filt_q)) begin
      if (stab_q != STAB_MAX) begin
        stab_d = stab_q + 1'b1;
      end
    end else begin
      stab_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= 1'b0;
      run_q   <= '0;
      stab_q  <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      filt_q  <= filt_d;
      run_q   <= run_d;
      stab_q  <= stab_d;
    end
  end

  assign filt   = filt_q;
  assign stable = (stab_q == STAB_MAX);

endmodule

// File: rtl/quad_encoder_counter.sv
// Quadrature encoder decoder with x1/x2/x4 resolution, wrapping or saturating
// position counter, direction pulses and illegal-transition detection.
module quad_encoder_counter
  import enc_pkg::*;
#(
  parameter int CNT_W        = 8,
  parameter int DEBOUNCE_CYC = 4,
  parameter int WRAP         = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic [1:0]       mode,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             step_cw,
  output logic             step_ccw,
  output logic             dir,
  output logic             err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             filt_a, filt_b;
  logic             stable_a, stable_b;
  logic [1:0]       filt_ab;
  enc_event_t       ev;

  logic [1:0]       prev_ab_q, prev_ab_d;
  logic             primed_q, primed_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             step_cw_q, step_cw_d;
  logic             step_ccw_q, step_ccw_d;
  logic             dir_q, dir_d;
  logic             err_q, err_d;

  enc_input_filter #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_filt_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw    (enc_a),
    .filt   (filt_a),
    .stable (stable_a)
  );

  enc_input_filter #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_filt_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw    (enc_b),
    .filt   (filt_b),
    .stable (stable_b)
  );

  assign filt_ab = {filt_a, filt_b};

  // Until primed, the resting position is captured silently instead of decoded
  always_comb begin
    prev_ab_d = prev_ab_q;
    primed_d  = primed_q;
    ev        = '0;
    if (!primed_q) begin
      if (stable_a && stable_b) begin
        primed_d  = 1'b1;
        prev_ab_d = filt_ab;
      end
    end else if (filt_ab != prev_ab_q) begin
      prev_ab_d = filt_ab;
      ev        = decode_step(mode, prev_ab_q, filt_ab);
    end
  end

  always_comb begin
    step_cw_d  = ev.cw;
    step_ccw_d = ev.ccw;
    err_d      = ev.err;
    dir_d      = dir_q;
    count_d    = count_q;
    if (ev.cw) begin
      dir_d = 1'b1;
    end else if (ev.ccw) begin
      dir_d = 1'b0;
    end
    // clr beats load beats the step; step pulses are reported regardless
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
    end else if (ev.cw) begin
      if ((WRAP == 0) && (count_q == CNT_MAX)) begin
        count_d = count_q;
      end else begin
        count_d = count_q + 1'b1;
      end
    end else if (ev.ccw) begin
      if ((WRAP == 0) && (count_q == '0)) begin
        count_d = count_q;
      end else begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_ab_q  <= 2'b00;
      primed_q   <= 1'b0;
      count_q    <= '0;
      step_cw_q  <= 1'b0;
      step_ccw_q <= 1'b0;
      dir_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      prev_ab_q  <= prev_ab_d;
      primed_q   <= primed_d;
      count_q    <= count_d;
      step_cw_q  <= step_cw_d;
      step_ccw_q <= step_ccw_d;
      dir_q      <= dir_d;
      err_q      <= err_d;
    end
  end

  assign count    = count_q;
  assign step_cw  = step_cw_q;
  assign step_ccw = step_ccw_q;
  assign dir      = dir_q;
  assign err      = err_q;

endmodule
